// File: rtl/vertical_gradient.sv
// ============================================================================
//  Module   : vertical_gradient
//  Purpose  : Vertical Sobel gradient magnitude |Gy| of a 3x3 pixel window.
//             gy is registered and held until the next start_calculations.
//  Options  : VERTICAL_GRADIENT_VALID_EN - adds the gy_valid strobe output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vertical_gradient (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  windowBuffer [0:8],
   input  logic        start_calculations,
   output logic [10:0] gy
`ifdef VERTICAL_GRADIENT_VALID_EN
   ,
   output logic        gy_valid
`endif
);

   // Weighted row sums; each is at most 255 + 510 + 255 = 1020 and fits in 10 bits.
   logic [9:0]         w_top_sum;
   logic [9:0]         w_bot_sum;
   // Signed difference bottom - top spans -1020..1020 and fits in 11 bits.
   logic signed [10:0] w_diff;
   logic [10:0]        w_abs;
   logic [10:0]        gy_d;
   logic [10:0]        gy_q;

   // The middle row carries zero weight in the vertical kernel.
   logic               w_unused_mid;
   assign w_unused_mid = ^{windowBuffer[3], windowBuffer[4], windowBuffer[5]};

   // Kernel sums, difference and magnitude feeding the result register.
   always_comb begin
      w_top_sum = {2'b00, windowBuffer[0]}
                + {1'b0,  windowBuffer[1], 1'b0}
                + {2'b00, windowBuffer[2]};
      w_bot_sum = {2'b00, windowBuffer[6]}
                + {1'b0,  windowBuffer[7], 1'b0}
                + {2'b00, windowBuffer[8]};
      w_diff    = $signed({1'b0, w_bot_sum}) - $signed({1'b0, w_top_sum});
      // The magnitude never exceeds 1020, so negating an 11-bit value cannot overflow.
      w_abs     = w_diff[10] ? 11'(-w_diff) : 11'(w_diff);
      gy_d      = start_calculations ? w_abs : gy_q;
   end

   // Result register: cleared by reset, loaded on a start edge, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         gy_q <= 11'd0;
      end else begin
         gy_q <= gy_d;
      end
   end

   assign gy = gy_q;

`ifdef VERTICAL_GRADIENT_VALID_EN
   logic gy_valid_d;
   logic gy_valid_q;

   // A new result is marked for exactly the cycle after each non-reset start edge.
   always_comb begin
      gy_valid_d = start_calculations;
   end

   // Strobe register; reset takes priority over a pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         gy_valid_q <= 1'b0;
      end else begin
         gy_valid_q <= gy_valid_d;
      end
   end

   assign gy_valid = gy_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vertical_gradient.sv
// ============================================================================
//  Module   : tb_vertical_gradient
//  Purpose  : Self-checking bench for vertical_gradient: directed vectors
//             followed by randomized windows against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vertical_gradient;

   logic        clk;
   logic        rst;
   logic [7:0]  win [0:8];
   logic        start;
   logic [10:0] gy;
`ifdef VERTICAL_GRADIENT_VALID_EN
   logic        gy_valid;
`endif

   int n_checks;
   int n_pass;

   // Reference model state
   int exp_gy;
   int exp_valid;

   vertical_gradient u_dut (
      .clk                (clk),
      .rst                (rst),
      .windowBuffer       (win),
      .start_calculations (start),
      .gy                 (gy)
`ifdef VERTICAL_GRADIENT_VALID_EN
      ,
      .gy_valid           (gy_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // |bottom - top| straight from the kernel definition.
   function automatic int ref_gy();
      int t, b, d;
      t = int'(win[0]) + 2 * int'(win[1]) + int'(win[2]);
      b = int'(win[6]) + 2 * int'(win[7]) + int'(win[8]);
      d = b - t;
      return (d < 0) ? -d : d;
   endfunction

   task automatic set_win(input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int a5,
                          input int a6, input int a7, input int a8);
      win[0] = 8'(a0); win[1] = 8'(a1); win[2] = 8'(a2);
      win[3] = 8'(a3); win[4] = 8'(a4); win[5] = 8'(a5);
      win[6] = 8'(a6); win[7] = 8'(a7); win[8] = 8'(a8);
   endtask

   task automatic rand_win();
      for (int i = 0; i < 9; i++) win[i] = 8'($urandom_range(0, 255));
   endtask

   // Apply inputs, clock once, update the model and compare one cycle later.
   task automatic step(input bit s, input bit r, input string tag);
      start = s;
      rst   = r;
      @(posedge clk);
      if (r) begin
         exp_gy    = 0;
         exp_valid = 0;
      end else if (s) begin
         exp_gy    = ref_gy();
         exp_valid = 1;
      end else begin
         exp_valid = 0;
      end
      #1;
      check(tag, int'(gy), exp_gy);
`ifdef VERTICAL_GRADIENT_VALID_EN
      check({tag, "_valid"}, int'(gy_valid), exp_valid);
`endif
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      exp_gy    = 0;
      exp_valid = 0;
      start     = 1'b0;
      rst       = 1'b1;
      rand_win();

      @(negedge clk);
      // Reset with start asserted and an arbitrary window
      step(1'b1, 1'b1, "reset1");
      step(1'b1, 1'b1, "reset2");
      check("reset_gy_zero", int'(gy), 0);

      set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1'b1, 1'b0, "zero_win");

      set_win(50, 255, 250, 100, 0, 200, 100, 255, 255);
      step(1'b1, 1'b0, "win55");
      check("win55_lit", int'(gy), 55);

      set_win(255, 255, 255, 255, 255, 255, 255, 255, 255);
      step(1'b1, 1'b0, "uniform255");
      check("uniform255_lit", int'(gy), 0);

      set_win(255, 255, 0, 155, 255, 205, 255, 255, 5);
      step(1'b1, 1'b0, "win5");
      check("win5_lit", int'(gy), 5);

      set_win(40, 255, 32, 255, 255, 100, 0, 255, 1);
      step(1'b1, 1'b0, "neg71");
      check("neg71_lit", int'(gy), 71);

      // Hold: window changes with start low must not disturb gy
      set_win(255, 255, 255, 255, 255, 255, 255, 255, 255);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "hold");
      check("hold_lit", int'(gy), 71);

      step(1'b1, 1'b1, "rst_over_start");
      check("rst_over_start_lit", int'(gy), 0);

      set_win(255, 255, 255, 0, 0, 0, 0, 0, 0);
      step(1'b1, 1'b0, "top_max");
      check("top_max_lit", int'(gy), 1020);

      set_win(0, 0, 0, 0, 0, 0, 255, 255, 255);
      step(1'b1, 1'b0, "bot_max");
      check("bot_max_lit", int'(gy), 1020);

      // Single start pulse followed by idle cycles
      rand_win();
      step(1'b1, 1'b0, "pulse");
      rand_win();
      step(1'b0, 1'b0, "pulse_idle1");
      step(1'b0, 1'b0, "pulse_idle2");

      // Randomized traffic: mixed start density and occasional reset
      for (int i = 0; i < 400; i++) begin
         rand_win();
         step(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 39) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
